reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised circular reorder buffer that replaces the hand-managed ROB array and its head, tail and count bookkeeping in the out-of-order core. It sits between dispatch, the CDB/commit stage and retire:
- Dispatch allocates 1-based tags.
- CDB broadcasts mark entries complete.
- Up to RETIRE_W completed entries retire in order per cycle.
- A single-cycle flush discards all speculative state.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥4.
- DATA_W, 64, result width.
- REG_W, 5, architectural register index width.
- CDB_PORTS, 2, number of completion broadcast ports.
- RETIRE_W, 2, maximum retirements per cycle; 1 ≤ RETIRE_W ≤ DEPTH.
- TAG_W (derived), $clog2(DEPTH+1); tag 0 means "no tag".

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  space available (!full).
- disp_rd  in  REG_W  destination register.
- disp_regwr  in  1  entry writes rd.
- disp_is_store  in  1  entry is a store.
- disp_tag  out  TAG_W  tag allocated if dispatch fires; equals tail index + 1.
- cdb_valid  in  [CDB_PORTS]  broadcast valid.
- cdb_tag  in  [CDB_PORTS][TAG_W]  completing tag.
- cdb_value  in  [CDB_PORTS][DATA_W]  result.
- ret_ready  in  1  retire consumer accepts this cycle.
- ret_valid  out  [RETIRE_W]  slot k retires; contiguous from slot 0.
- ret_tag  out  [RETIRE_W][TAG_W]  retiring tag.
- ret_rd  out  [RETIRE_W][REG_W]  retiring destination register.
- ret_value  out  [RETIRE_W][DATA_W]  retiring result value.
- ret_regwr  out  [RETIRE_W]  retiring entry writes rd.
- ret_is_store  out  [RETIRE_W]  retiring entry is a store.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Entry fields: busy, ready, rd, regwr, is_store, value.
- Pointers: head and tail are $clog2(DEPTH)-bit indices that wrap naturally.
- Dispatch fires when disp_valid && disp_ready:
  - writes entry[tail] with busy=1, ready=0, value=0;
  - tail advances by 1.
- CDB: for each port p with cdb_valid[p] and a nonzero tag, entry[cdb_tag[p]-1] gets ready=1 and value=cdb_value[p], but only if that entry is busy.
  - A CDB write to a non-busy entry is ignored.
  - If two ports carry the same tag, the higher-numbered port wins.
- Retire selection (combinational, registered state only): slot k is valid iff:
  - entries head..head+k are all busy and ready;
  - no earlier slot in the group was a store unless k = 0, so at most one store retires per cycle and it must be in slot 0 (a store in slot 1+ ends the group);
  - ret_ready = 1.
- On retire, retired entries are cleared (busy=0, ready=0) and head advances by the number of valid slots.
- count update: next = count + dispatched − retired. Dispatch and retire in the same cycle are both honoured.
- Flush: all busy and ready bits cleared, head = tail = count = 0. Flush overrides dispatch, CDB and retire in that cycle, and ret_valid is forced to 0 while flush = 1.
- Reset: same effect as flush, plus all entry fields zeroed.

## Timing
- Reset values: disp_ready=1, disp_tag=1, all ret_* = 0, count=0, empty=1, full=0.
- Dispatch to visible: an entry written at edge N is in count and scanned for retire from cycle N+1.
- CDB to retire: CDB at edge N makes the entry retirable in cycle N+1 (no same-cycle bypass).
- disp_ready depends only on registered count. When full, a same-cycle retire does not enable dispatch; dispatch resumes the following cycle.
- Wrap-around: tag DEPTH is followed by tag 1, and head and tail may each wrap independently within a cycle.
- ret_* outputs are combinational from registered state plus ret_ready and flush; consumers sample them at the edge.

## Structure
- Shared consts file: default ROB_SIZE, the NO_TAG constant (0) and the retire width constant.
- The entry struct depends on parameters and is declared locally.
- One sub-module, rob_retire_select: a combinational scan of RETIRE_W entries from head. It outputs per-slot valid (with the store rule applied) and the retire count.

## Test plan
- Reset, then dispatch 3 entries (rd 5/6/7, regwr=1) → disp_tag 1,2,3; count=3; no ret_valid.
- CDB tag 2 value 0xAA, then tag 1 value 0x55, with ret_ready=1 → retire tags 1 and 2 together (values 0x55, 0xAA); count=1.
- Fill DEPTH=16 → full=1, disp_ready=0. Retire 2 while disp_valid=1 → no dispatch that cycle, dispatch next cycle with tag 1 (wrap).
- Head entries store, store, both ready → one store per cycle over 2 cycles. Then ALU, store both ready → ALU alone retires first.
- Both CDB ports carry tag 4 (0x1 / 0x2) → value 0x2 retires. A CDB to a non-busy tag 9 → no state change.
- Flush with 5 busy entries plus a simultaneous dispatch and CDB → next cycle count=0, empty=1, disp_tag=1, no ret_valid.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// ============================================================
// reorder_buffer_pkg : shared ROB constants
// Rev 1.0
// ============================================================
`default_nettype none

package reorder_buffer_pkg;
  localparam int ROB_SIZE     = 16;
  localparam int NO_TAG       = 0;
  localparam int RETIRE_WIDTH = 2;
endpackage

`default_nettype wire

// File: rtl/reorder_buffer_if.sv
// ============================================================
// reorder_buffer_if : dispatch / CDB / retire bundle of the ROB
// Rev 1.0
// ============================================================
`default_nettype none

interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH     = ROB_SIZE,
  parameter int DATA_W    = 64,
  parameter int REG_W     = 5,
  parameter int CDB_PORTS = 2,
  parameter int RETIRE_W  = RETIRE_WIDTH,
  parameter int TAG_W     = $clog2(DEPTH + 1)
);
  logic                                 flush;
  logic                                 disp_valid;
  logic                                 disp_ready;
  logic [REG_W-1:0]                     disp_rd;
  logic                                 disp_regwr;
  logic                                 disp_is_store;
  logic [TAG_W-1:0]                     disp_tag;
  logic [CDB_PORTS-1:0]                 cdb_valid;
  logic [CDB_PORTS-1:0][TAG_W-1:0]      cdb_tag;
  logic [CDB_PORTS-1:0][DATA_W-1:0]     cdb_value;
  logic                                 ret_ready;
  logic [RETIRE_W-1:0]                  ret_valid;
  logic [RETIRE_W-1:0][TAG_W-1:0]       ret_tag;
  logic [RETIRE_W-1:0][REG_W-1:0]       ret_rd;
  logic [RETIRE_W-1:0][DATA_W-1:0]      ret_value;
  logic [RETIRE_W-1:0]                  ret_regwr;
  logic [RETIRE_W-1:0]                  ret_is_store;
  logic [TAG_W-1:0]                     count;
  logic                                 empty;
  logic                                 full;

  modport master (
    output flush, disp_valid, disp_rd, disp_regwr, disp_is_store,
           cdb_valid, cdb_tag, cdb_value, ret_ready,
    input  disp_ready, disp_tag, ret_valid, ret_tag, ret_rd, ret_value,
           ret_regwr, ret_is_store, count, empty, full
  );

  modport slave (
    input  flush, disp_valid, disp_rd, disp_regwr, disp_is_store,
           cdb_valid, cdb_tag, cdb_value, ret_ready,
    output disp_ready, disp_tag, ret_valid, ret_tag, ret_rd, ret_value,
           ret_regwr, ret_is_store, count, empty, full
  );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer_retire_select.sv
// ============================================================
// rob_retire_select : in-order retire group selection from head
// Rev 1.0
// ============================================================
`default_nettype none

module rob_retire_select #(
  parameter int RETIRE_W = 2,
  parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
  input  logic [RETIRE_W-1:0] busy,
  input  logic [RETIRE_W-1:0] ready,
  input  logic [RETIRE_W-1:0] is_store,
  input  logic                ret_ready,
  input  logic                flush,
  output logic [RETIRE_W-1:0] valid,
  output logic [CNT_W-1:0]    cnt
);

  // A store may only occupy slot 0, and nothing retires behind it.
  always_comb begin
    valid    = '0;
    valid[0] = busy[0] && ready[0] && ret_ready && !flush;
    for (int k = 1; k < RETIRE_W; k++) begin
      valid[k] = valid[k-1] && busy[k] && ready[k] && !is_store[k-1] && !is_store[k];
    end
    cnt = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      cnt = cnt + CNT_W'(valid[k]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================
// reorder_buffer : circular ROB with CDB completion and in-order retire
// Rev 1.0
// ============================================================
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH     = ROB_SIZE,
  parameter int DATA_W    = 64,
  parameter int REG_W     = 5,
  parameter int CDB_PORTS = 2,
  parameter int RETIRE_W  = RETIRE_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  reorder_buffer_if.slave bus
);

  localparam int TAG_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int RC_W  = $clog2(RETIRE_W + 1);

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [REG_W-1:0]  rd;
    logic              regwr;
    logic              is_store;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t              rob_q [DEPTH];
  entry_t              rob_d [DEPTH];
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0]    count_q, count_d;
  logic                full;
  logic                disp_fire;
  logic [IDX_W-1:0]    slot_idx [RETIRE_W];
  logic [RETIRE_W-1:0] sel_busy, sel_ready, sel_store, ret_valid;
  logic [RC_W-1:0]     ret_cnt;
  logic [IDX_W-1:0]    cdb_idx;

  assign full      = (count_q == TAG_W'(DEPTH));
  assign disp_fire = bus.disp_valid && !full;

  always_comb begin
    for (int k = 0; k < RETIRE_W; k++) begin
      slot_idx[k]  = head_q + IDX_W'(k);
      sel_busy[k]  = rob_q[slot_idx[k]].busy;
      sel_ready[k] = rob_q[slot_idx[k]].ready;
      sel_store[k] = rob_q[slot_idx[k]].is_store;
    end
  end

  rob_retire_select #(
    .RETIRE_W (RETIRE_W),
    .CNT_W    (RC_W)
  ) u_retire_select (
    .busy      (sel_busy),
    .ready     (sel_ready),
    .is_store  (sel_store),
    .ret_ready (bus.ret_ready),
    .flush     (bus.flush),
    .valid     (ret_valid),
    .cnt       (ret_cnt)
  );

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cdb_idx = '0;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_d[i].busy  = 1'b0;
        rob_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest port wins on a tag clash.
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] && bus.cdb_tag[p] != TAG_W'(NO_TAG) &&
            bus.cdb_tag[p] <= TAG_W'(DEPTH)) begin
          cdb_idx = IDX_W'(bus.cdb_tag[p] - TAG_W'(1));
          if (rob_q[cdb_idx].busy) begin
            rob_d[cdb_idx].ready = 1'b1;
            rob_d[cdb_idx].value = bus.cdb_value[p];
          end
        end
      end
      for (int k = 0; k < RETIRE_W; k++) begin
        if (ret_valid[k]) begin
          rob_d[slot_idx[k]].busy  = 1'b0;
          rob_d[slot_idx[k]].ready = 1'b0;
        end
      end
      // The tail slot is never busy when dispatch fires, so no retire/CDB conflict here.
      if (disp_fire) begin
        rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: bus.disp_rd,
                          regwr: bus.disp_regwr, is_store: bus.disp_is_store,
                          value: '0};
      end
      head_d  = head_q + IDX_W'(ret_cnt);
      tail_d  = tail_q + IDX_W'(disp_fire);
      count_d = count_q + TAG_W'(disp_fire) - TAG_W'(ret_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    bus.disp_ready = !full;
    bus.disp_tag   = TAG_W'(tail_q) + TAG_W'(1);
    bus.count      = count_q;
    bus.empty      = (count_q == '0);
    bus.full       = full;
    for (int k = 0; k < RETIRE_W; k++) begin
      bus.ret_valid[k]    = ret_valid[k];
      bus.ret_tag[k]      = ret_valid[k] ? TAG_W'(slot_idx[k]) + TAG_W'(1) : '0;
      bus.ret_rd[k]       = ret_valid[k] ? rob_q[slot_idx[k]].rd : '0;
      bus.ret_value[k]    = ret_valid[k] ? rob_q[slot_idx[k]].value : '0;
      bus.ret_regwr[k]    = ret_valid[k] && rob_q[slot_idx[k]].regwr;
      bus.ret_is_store[k] = ret_valid[k] && rob_q[slot_idx[k]].is_store;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================
// tb_reorder_buffer : directed + random bench against a queue model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_reorder_buffer;
  localparam int DEPTH     = 16;
  localparam int DATA_W    = 64;
  localparam int REG_W     = 5;
  localparam int CDB_PORTS = 2;
  localparam int RETIRE_W  = 2;
  localparam int TAG_W     = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W),
                      .CDB_PORTS(CDB_PORTS), .RETIRE_W(RETIRE_W), .TAG_W(TAG_W)) bus ();

  reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W),
                   .CDB_PORTS(CDB_PORTS), .RETIRE_W(RETIRE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: program-order queue of in-flight instructions.
  typedef struct {
    int                tag;
    logic [REG_W-1:0]  rd;
    bit                regwr;
    bit                st;
    bit                rdy;
    logic [DATA_W-1:0] val;
  } m_ent_t;

  m_ent_t mq[$];
  int     next_tag = 1;
  int     total    = 0;
  int     bad      = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int exp_ret_n();
    int n = 0;
    if (!bus.ret_ready || bus.flush) return 0;
    for (int k = 0; k < RETIRE_W && k < mq.size(); k++) begin
      if (!mq[k].rdy) break;
      if (k > 0 && (mq[k].st || mq[k-1].st)) break;
      n++;
    end
    return n;
  endfunction

  task automatic check_outputs();
    int n = exp_ret_n();
    chk("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < DEPTH));
    chk("disp_tag",   64'(bus.disp_tag),   64'(next_tag));
    chk("count",      64'(bus.count),      64'(mq.size()));
    chk("empty",      64'(bus.empty),      64'(mq.size() == 0));
    chk("full",       64'(bus.full),       64'(mq.size() == DEPTH));
    for (int k = 0; k < RETIRE_W; k++) begin
      chk($sformatf("ret_valid[%0d]", k), 64'(bus.ret_valid[k]), 64'(k < n));
      if (k < n) begin
        chk($sformatf("ret_tag[%0d]", k),   64'(bus.ret_tag[k]),      64'(mq[k].tag));
        chk($sformatf("ret_rd[%0d]", k),    64'(bus.ret_rd[k]),       64'(mq[k].rd));
        chk($sformatf("ret_value[%0d]", k), bus.ret_value[k],         mq[k].val);
        chk($sformatf("ret_regwr[%0d]", k), 64'(bus.ret_regwr[k]),    64'(mq[k].regwr));
        chk($sformatf("ret_store[%0d]", k), 64'(bus.ret_is_store[k]), 64'(mq[k].st));
      end
    end
  endtask

  task automatic idle();
    bus.flush         = 1'b0;
    bus.disp_valid    = 1'b0;
    bus.disp_rd       = '0;
    bus.disp_regwr    = 1'b0;
    bus.disp_is_store = 1'b0;
    bus.cdb_valid     = '0;
    bus.cdb_tag       = '0;
    bus.cdb_value     = '0;
    bus.ret_ready     = 1'b0;
  endtask

  // Check outputs against the model, clock once, then advance the model.
  task automatic cycle();
    int     n;
    bit     fire;
    m_ent_t e;
    #1;
    if (!reset) check_outputs();
    n    = exp_ret_n();
    fire = bus.disp_valid && (mq.size() < DEPTH);
    @(posedge clk);
    if (reset || bus.flush) begin
      mq.delete();
      next_tag = 1;
    end else begin
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (bus.cdb_valid[p] && bus.cdb_tag[p] != 0) begin
          foreach (mq[i]) begin
            if (mq[i].tag == int'(bus.cdb_tag[p])) begin
              mq[i].rdy = 1'b1;
              mq[i].val = bus.cdb_value[p];
            end
          end
        end
      end
      repeat (n) void'(mq.pop_front());
      if (fire) begin
        e.tag   = next_tag;
        e.rd    = bus.disp_rd;
        e.regwr = bus.disp_regwr;
        e.st    = bus.disp_is_store;
        e.rdy   = 1'b0;
        e.val   = '0;
        mq.push_back(e);
        next_tag = (next_tag == DEPTH) ? 1 : next_tag + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic dispatch(input int rd, input bit regwr, input bit st);
    bus.disp_valid    = 1'b1;
    bus.disp_rd       = REG_W'(rd);
    bus.disp_regwr    = regwr;
    bus.disp_is_store = st;
    cycle();
    bus.disp_valid    = 1'b0;
  endtask

  task automatic cdb(input int p, input int tag, input logic [63:0] val);
    bus.cdb_valid[p] = 1'b1;
    bus.cdb_tag[p]   = TAG_W'(tag);
    bus.cdb_value[p] = val;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;

    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_disp_tag",   64'(bus.disp_tag),   64'd1);
    chk("rst_count",      64'(bus.count),      64'd0);
    chk("rst_empty",      64'(bus.empty),      64'd1);
    chk("rst_full",       64'(bus.full),       64'd0);
    chk("rst_ret_valid",  64'(bus.ret_valid),  64'd0);
    chk("rst_ret_tag",    64'(bus.ret_tag),    64'd0);

    // Three dispatches, tags 1..3
    for (int i = 0; i < 3; i++) begin
      chk("tp1_disp_tag", 64'(bus.disp_tag), 64'(i + 1));
      dispatch(5 + i, 1'b1, 1'b0);
    end
    chk("tp1_count", 64'(bus.count), 64'd3);
    chk("tp1_ret_valid", 64'(bus.ret_valid), 64'd0);

    // Out-of-order completion, in-order dual retire
    cdb(0, 2, 64'hAA); cycle(); idle();
    cdb(0, 1, 64'h55); cycle(); idle();
    bus.ret_ready = 1'b1;
    #1;
    chk("tp2_ret_valid", 64'(bus.ret_valid), 64'b11);
    chk("tp2_val0", bus.ret_value[0], 64'h55);
    chk("tp2_val1", bus.ret_value[1], 64'hAA);
    cycle(); idle();
    chk("tp2_count", 64'(bus.count), 64'd1);

    // Fill to full; tags wrap past DEPTH
    for (int i = 0; i < 15; i++) dispatch(i, 1'b1, 1'b0);
    chk("tp3_full", 64'(bus.full), 64'd1);
    chk("tp3_disp_ready", 64'(bus.disp_ready), 64'd0);
    cdb(0, 3, 64'h33); cdb(1, 4, 64'h44); cycle(); idle();
    bus.ret_ready  = 1'b1;
    bus.disp_valid = 1'b1;
    #1;
    chk("tp3_ret_full", 64'(bus.ret_valid), 64'b11);
    chk("tp3_no_disp", 64'(bus.disp_ready), 64'd0);
    cycle();
    bus.ret_ready = 1'b0;
    chk("tp3_count14", 64'(bus.count), 64'd14);
    chk("tp3_ready_again", 64'(bus.disp_ready), 64'd1);
    chk("tp3_wrap_tag", 64'(bus.disp_tag), 64'd3);
    cycle(); idle();

    // Flush with ret_ready, dispatch and CDB all active
    bus.flush = 1'b1; bus.ret_ready = 1'b1; bus.disp_valid = 1'b1; cdb(0, 5, 64'h77);
    #1;
    chk("fl_ret_valid", 64'(bus.ret_valid), 64'd0);
    cycle(); idle();
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_tag", 64'(bus.disp_tag), 64'd1);

    // Store rule: st, st, alu, st
    dispatch(1, 1'b0, 1'b1);
    dispatch(2, 1'b0, 1'b1);
    dispatch(3, 1'b1, 1'b0);
    dispatch(4, 1'b0, 1'b1);
    cdb(0, 1, 64'h1); cdb(1, 2, 64'h2); cycle(); idle();
    cdb(0, 3, 64'h3); cdb(1, 4, 64'h4); cycle(); idle();
    bus.ret_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      #1;
      chk("st_ret_valid", 64'(bus.ret_valid), 64'b01);
      chk("st_ret_tag", 64'(bus.ret_tag[0]), 64'(t));
      cycle();
    end
    idle();

    // Same tag on both ports; CDB to a non-busy tag
    bus.flush = 1'b1; cycle(); idle();
    for (int i = 0; i < 4; i++) dispatch(10 + i, 1'b1, 1'b0);
    cdb(0, 4, 64'h1); cdb(1, 4, 64'h2); cycle(); idle();
    cdb(0, 9, 64'hDEAD); cdb(1, 1, 64'h11); cycle(); idle();
    cdb(0, 2, 64'h22); cdb(1, 3, 64'h33); cycle(); idle();
    chk("cdb_count", 64'(bus.count), 64'd4);
    bus.ret_ready = 1'b1;
    cycle();
    #1;
    chk("cdb_tag4", 64'(bus.ret_tag[1]), 64'd4);
    chk("cdb_val4", bus.ret_value[1], 64'h2);
    cycle(); idle();

    // Flush with 5 busy entries plus dispatch and CDB
    for (int i = 0; i < 5; i++) dispatch(20 + i, 1'b1, 1'b0);
    chk("fl5_count", 64'(bus.count), 64'd5);
    bus.flush = 1'b1; bus.disp_valid = 1'b1; cdb(0, 9, 64'h99);
    cycle(); idle();
    chk("fl5_count0", 64'(bus.count), 64'd0);
    chk("fl5_empty", 64'(bus.empty), 64'd1);
    chk("fl5_tag", 64'(bus.disp_tag), 64'd1);
    chk("fl5_ret", 64'(bus.ret_valid), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.flush         = ($urandom_range(0, 59) == 0);
      bus.disp_valid    = ($urandom_range(0, 9) < 7);
      bus.disp_rd       = REG_W'($urandom());
      bus.disp_regwr    = 1'($urandom());
      bus.disp_is_store = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < CDB_PORTS; p++) begin
        bus.cdb_valid[p] = 1'($urandom());
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          bus.cdb_tag[p] = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else
          bus.cdb_tag[p] = TAG_W'($urandom_range(0, DEPTH));
        bus.cdb_value[p] = {$urandom(), $urandom()};
      end
      bus.ret_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
